// File: rtl/kw_ram_1rws_req_ctrl.sv
// Request-side controller for a single-port 1RW SRAM: valid/ready requests in, in-order read
// responses out through a small credit-protected FIFO. Optional macro: KW_RAM_CTRL_WRITE_ACK_EN.
module kw_ram_1rws_req_ctrl #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned RSP_DEPTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs_n,
  output logic                  ram_we_n,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam logic [CntW:0]   RspDepthW = (CntW + 1)'(RSP_DEPTH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(RSP_DEPTH - 1);

`ifdef KW_RAM_CTRL_WRITE_ACK_EN
  localparam bit WriteAck = 1'b1;
`else
  localparam bit WriteAck = 1'b0;
`endif

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_wr_q, s1_wr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

  logic            fire, push, pop, credit_ok;
  logic [CntW:0]   used;
  logic [DATA_WIDTH-1:0] push_data;

  // Credits cover both queued entries and the read still in the SRAM pipeline.
  assign used      = {1'b0, count_q} + {{CntW{1'b0}}, s1_valid_q};
  assign credit_ok = used < RspDepthW;
  assign req_ready = reset_n & (credit_ok | (req_we & ~WriteAck));

  assign fire      = req_valid & req_ready;
  assign ram_cs_n  = ~fire;
  assign ram_we_n  = ~(fire & req_we);
  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;

  assign push      = s1_valid_q;
  assign push_data = s1_wr_q ? '0 : ram_rdata;
  assign rsp_valid = reset_n & (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = mem_q[rd_ptr_q];

  always_comb begin
    s1_valid_d = fire & (~req_we | WriteAck);
    s1_wr_d    = req_we;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_wr_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s1_valid_q <= s1_valid_d;
      s1_wr_q    <= s1_wr_d;
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  no_overflow_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count_q == CntW'(RSP_DEPTH))));

endmodule
